register_writeback: RTL and testbench

Write-side producer for register_bank. Collects results from the ALU and memory-load paths, queues them in a small in-order buffer, and drains one entry per cycle onto the bank's single write port (WC/WPC/W_RB). Also exposes pending-write forwarding, so operand reads on RA/RB never return a stale value while a write is still queued.

---
 rtl/register_writeback_pkg.sv | 21 ++
 rtl/register_writeback_wb_fifo.sv | 70 +++++++
 rtl/register_writeback.sv | 123 ++++++++++++
 tb/tb_register_writeback.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/register_writeback_pkg.sv
// Shared widths and payload types for the register write-back path.
package register_writeback_pkg;

    localparam int unsigned WB_DATA_W   = 32;
    localparam int unsigned WB_ADDR_W   = 4;
    localparam int unsigned WB_NUM_REGS = 1 << WB_ADDR_W;
    localparam int unsigned WB_DEPTH    = 4;
    localparam int unsigned WB_ENTRY_W  = WB_ADDR_W + WB_DATA_W;

    // One pending register write: destination index and value.
    typedef struct packed {
        logic [WB_ADDR_W-1:0] wc;
        logic [WB_DATA_W-1:0] data;
    } wb_entry_t;

    // Occupancy counter width for a buffer of the given depth (0..depth inclusive).
    function automatic int unsigned wb_cnt_w(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/register_writeback_wb_fifo.sv
// In-order write buffer: two pushes (a older than b) and one pop per cycle,
// with a flattened storage/valid view for the forwarding search.
module wb_fifo
    import register_writeback_pkg::*;
#(
    parameter  int unsigned ENTRY_W = WB_ENTRY_W,
    parameter  int unsigned DEPTH   = WB_DEPTH,
    localparam int unsigned PTR_W   = $clog2(DEPTH),
    localparam int unsigned CNT_W   = wb_cnt_w(DEPTH)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push_a,
    input  logic [ENTRY_W-1:0]         data_a,
    input  logic                       push_b,
    input  logic [ENTRY_W-1:0]         data_b,
    input  logic                       pop,
    output logic [DEPTH*ENTRY_W-1:0]   entries,
    output logic [DEPTH-1:0]           valid,
    output logic [PTR_W-1:0]           head,
    output logic [CNT_W-1:0]           count
);

    logic [ENTRY_W-1:0] mem_q [DEPTH];
    logic [DEPTH-1:0]   valid_q;
    logic [PTR_W-1:0]   head_q;
    logic [PTR_W-1:0]   tail_q;
    logic [CNT_W-1:0]   count_q;
    logic [PTR_W-1:0]   tail_nx;

    assign tail_nx = tail_q + PTR_W'(1);

    // Storage, pointers and occupancy; a push into the slot being popped wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned k = 0; k < DEPTH; k++) begin
                mem_q[k] <= '0;
            end
            valid_q <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            if (pop) begin
                valid_q[head_q] <= 1'b0;
                head_q          <= head_q + PTR_W'(1);
            end
            if (push_a) begin
                mem_q[tail_q]   <= data_a;
                valid_q[tail_q] <= 1'b1;
            end
            if (push_b) begin
                mem_q[tail_nx]   <= data_b;
                valid_q[tail_nx] <= 1'b1;
            end
            tail_q  <= tail_q + PTR_W'(push_a) + PTR_W'(push_b);
            count_q <= count_q + CNT_W'(push_a) + CNT_W'(push_b) - CNT_W'(pop);
        end
    end

    // Flattened view of every slot for the forwarding search.
    for (genvar k = 0; k < DEPTH; k++) begin : g_flat
        assign entries[k*ENTRY_W +: ENTRY_W] = mem_q[k];
    end

    assign valid = valid_q;
    assign head  = head_q;
    assign count = count_q;

endmodule

// File: rtl/register_writeback.sv
// Write-side producer for register_bank: arbitrates load/ALU results into an
// in-order buffer, drains one write per cycle and forwards pending writes.
module register_writeback
    import register_writeback_pkg::*;
#(
    parameter  int unsigned DATA_W = WB_DATA_W,
    parameter  int unsigned ADDR_W = WB_ADDR_W,
    parameter  int unsigned DEPTH  = WB_DEPTH,
    localparam int unsigned CNT_W  = wb_cnt_w(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mem_valid,
    input  logic [ADDR_W-1:0] mem_wc,
    input  logic [DATA_W-1:0] mem_data,
    output logic              mem_ready,
    input  logic              alu_valid,
    input  logic [ADDR_W-1:0] alu_wc,
    input  logic [DATA_W-1:0] alu_data,
    output logic              alu_ready,
    output logic [ADDR_W-1:0] wc,
    output logic [DATA_W-1:0] wpc,
    output logic              w_rb,
    input  logic [ADDR_W-1:0] ra,
    input  logic [ADDR_W-1:0] rb,
    output logic              fwd_a_hit,
    output logic              fwd_b_hit,
    output logic [DATA_W-1:0] fwd_a_data,
    output logic [DATA_W-1:0] fwd_b_data,
    output logic [CNT_W-1:0]  count,
    output logic              full,
    output logic              empty
);

    localparam int unsigned ENTRY_W = ADDR_W + DATA_W;
    localparam int unsigned PTR_W   = $clog2(DEPTH);

    typedef struct packed {
        logic [ADDR_W-1:0] wc;
        logic [DATA_W-1:0] data;
    } entry_t;

    logic [DEPTH*ENTRY_W-1:0] entries;
    logic [DEPTH-1:0]         valid;
    logic [PTR_W-1:0]         head;
    entry_t                   ent [DEPTH];

    logic [CNT_W-1:0] free_c;
    logic             mem_acc;
    logic             alu_acc;
    logic             push_a;
    logic             push_b;
    entry_t           data_a;
    entry_t           data_b;
    logic             pop;
    logic [PTR_W-1:0] idx;

    assign empty = (count == '0);
    assign full  = (count == CNT_W'(DEPTH));
    assign pop   = !empty;

    // Free slots include the credit of the head draining this cycle.
    assign free_c    = CNT_W'(DEPTH) - count + CNT_W'(!empty);
    assign mem_ready = (free_c >= CNT_W'(1));
    assign alu_ready = (free_c >= CNT_W'(2)) || ((free_c >= CNT_W'(1)) && !mem_valid);

    assign mem_acc = mem_valid && mem_ready;
    assign alu_acc = alu_valid && alu_ready;

    // Load result is older than an ALU result accepted in the same cycle.
    assign push_a = mem_acc || alu_acc;
    assign push_b = mem_acc && alu_acc;
    assign data_a = mem_acc ? entry_t'{wc: mem_wc, data: mem_data}
                            : entry_t'{wc: alu_wc, data: alu_data};
    assign data_b = entry_t'{wc: alu_wc, data: alu_data};

    wb_fifo #(
        .ENTRY_W (ENTRY_W),
        .DEPTH   (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_a  (push_a),
        .data_a  (data_a),
        .push_b  (push_b),
        .data_b  (data_b),
        .pop     (pop),
        .entries (entries),
        .valid   (valid),
        .head    (head),
        .count   (count)
    );

    for (genvar k = 0; k < DEPTH; k++) begin : g_unpack
        assign ent[k] = entry_t'(entries[k*ENTRY_W +: ENTRY_W]);
    end

    // Bank write port: head entry, forced to zero while the buffer is empty.
    assign w_rb = !empty;
    assign wc   = empty ? '0 : ent[head].wc;
    assign wpc  = empty ? '0 : ent[head].data;

    // Forwarding: scan oldest to youngest so the youngest match is kept.
    always_comb begin
        fwd_a_hit  = 1'b0;
        fwd_a_data = '0;
        fwd_b_hit  = 1'b0;
        fwd_b_data = '0;
        idx        = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            idx = head + PTR_W'(i);
            if (valid[idx] && (ent[idx].wc == ra)) begin
                fwd_a_hit  = 1'b1;
                fwd_a_data = ent[idx].data;
            end
            if (valid[idx] && (ent[idx].wc == rb)) begin
                fwd_b_hit  = 1'b1;
                fwd_b_data = ent[idx].data;
            end
        end
    end

endmodule

// File: tb/tb_register_writeback.sv
// Randomized and directed bench for register_writeback with a queue-based
// reference model and a behavioural register bank.
module tb_register_writeback;

    localparam int DEPTH = 4;

    typedef struct packed {
        logic [3:0]  wc;
        logic [31:0] data;
    } ent_t;

    logic        clk;
    logic        rst_n;
    logic        mem_valid;
    logic [3:0]  mem_wc;
    logic [31:0] mem_data;
    logic        mem_ready;
    logic        alu_valid;
    logic [3:0]  alu_wc;
    logic [31:0] alu_data;
    logic        alu_ready;
    logic [3:0]  wc;
    logic [31:0] wpc;
    logic        w_rb;
    logic [3:0]  ra;
    logic [3:0]  rb;
    logic        fwd_a_hit;
    logic        fwd_b_hit;
    logic [31:0] fwd_a_data;
    logic [31:0] fwd_b_data;
    logic [2:0]  count;
    logic        full;
    logic        empty;

    int          n_checks;
    int          n_fail;
    int          dut_max_count;
    ent_t        q[$];
    logic [31:0] exp_bank [16];
    logic [31:0] tb_bank  [16];

    register_writeback dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .mem_valid  (mem_valid),
        .mem_wc     (mem_wc),
        .mem_data   (mem_data),
        .mem_ready  (mem_ready),
        .alu_valid  (alu_valid),
        .alu_wc     (alu_wc),
        .alu_data   (alu_data),
        .alu_ready  (alu_ready),
        .wc         (wc),
        .wpc        (wpc),
        .w_rb       (w_rb),
        .ra         (ra),
        .rb         (rb),
        .fwd_a_hit  (fwd_a_hit),
        .fwd_b_hit  (fwd_b_hit),
        .fwd_a_data (fwd_a_data),
        .fwd_b_data (fwd_b_data),
        .count      (count),
        .full       (full),
        .empty      (empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One cycle: drive inputs, compare every output to the model, advance model.
    task automatic step(input logic mv, input logic [3:0] mwc, input logic [31:0] md,
                        input logic av, input logic [3:0] awc, input logic [31:0] ad,
                        input logic [3:0] ra_i, input logic [3:0] rb_i,
                        output logic m_acc, output logic a_acc);
        int   sz;
        int   fr;
        logic e_mr, e_ar;
        logic ea_hit, eb_hit;
        logic [31:0] ea_data, eb_data;
        ent_t e;
        @(negedge clk);
        mem_valid = mv; mem_wc = mwc; mem_data = md;
        alu_valid = av; alu_wc = awc; alu_data = ad;
        ra = ra_i; rb = rb_i;
        #1;
        sz   = q.size();
        fr   = DEPTH - sz + ((sz > 0) ? 1 : 0);
        e_mr = (fr >= 1);
        e_ar = (fr >= 2) || ((fr >= 1) && !mv);
        ea_hit = 1'b0; ea_data = 32'h0;
        eb_hit = 1'b0; eb_data = 32'h0;
        foreach (q[i]) begin
            if (q[i].wc == ra_i) begin ea_hit = 1'b1; ea_data = q[i].data; end
            if (q[i].wc == rb_i) begin eb_hit = 1'b1; eb_data = q[i].data; end
        end
        check("mem_ready", 64'(mem_ready), 64'(e_mr));
        check("alu_ready", 64'(alu_ready), 64'(e_ar));
        check("w_rb",      64'(w_rb),      64'(sz > 0));
        check("wc",        64'(wc),        64'((sz > 0) ? q[0].wc : 4'h0));
        check("wpc",       64'(wpc),       64'((sz > 0) ? q[0].data : 32'h0));
        check("count",     64'(count),     64'(sz));
        check("full",      64'(full),      64'(sz == DEPTH));
        check("empty",     64'(empty),     64'(sz == 0));
        check("fwd_a_hit", 64'(fwd_a_hit), 64'(ea_hit));
        check("fwd_a_data",64'(fwd_a_data),64'(ea_data));
        check("fwd_b_hit", 64'(fwd_b_hit), 64'(eb_hit));
        check("fwd_b_data",64'(fwd_b_data),64'(eb_data));
        if (int'(count) > dut_max_count) dut_max_count = int'(count);
        if (w_rb) tb_bank[wc] = wpc;
        if (sz > 0) begin
            e = q.pop_front();
            exp_bank[e.wc] = e.data;
        end
        m_acc = mv && e_mr;
        a_acc = av && e_ar;
        if (m_acc) q.push_back(ent_t'{wc: mwc, data: md});
        if (a_acc) q.push_back(ent_t'{wc: awc, data: ad});
    endtask

    task automatic idle(input int n, input logic [3:0] ra_i, input logic [3:0] rb_i);
        logic ma, aa;
        for (int i = 0; i < n; i++) step(1'b0, 4'h0, 32'h0, 1'b0, 4'h0, 32'h0, ra_i, rb_i, ma, aa);
    endtask

    task automatic compare_bank(input string tag);
        for (int i = 0; i < 16; i++) check(tag, 64'(tb_bank[i]), 64'(exp_bank[i]));
    endtask

    initial begin
        logic ma, aa;
        int   nm, na, guard;
        n_checks = 0;
        n_fail   = 0;
        dut_max_count = 0;
        for (int i = 0; i < 16; i++) begin
            exp_bank[i] = 32'hDEAD_0000 | 32'(i);
            tb_bank[i]  = 32'hDEAD_0000 | 32'(i);
        end
        rst_n = 1'b0;
        mem_valid = 1'b0; mem_wc = 4'h0; mem_data = 32'h0;
        alu_valid = 1'b0; alu_wc = 4'h0; alu_data = 32'h0;
        ra = 4'h0; rb = 4'h0;
        #1;
        check("rst_w_rb",  64'(w_rb),  64'd0);
        check("rst_count", 64'(count), 64'd0);
        check("rst_empty", 64'(empty), 64'd1);
        check("rst_full",  64'(full),  64'd0);
        check("rst_wpc",   64'(wpc),   64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Single ALU write with latency of one cycle.
        step(1'b0, 4'h0, 32'h0, 1'b1, 4'd5, 32'h0000_0005, 4'd5, 4'd0, ma, aa);
        idle(2, 4'd5, 4'd5);
        check("single_r5", 64'(tb_bank[5]), 64'h0000_0005);

        // Simultaneous load and ALU to the same register: load first, ALU wins.
        step(1'b1, 4'd3, 32'hAAAA_0003, 1'b1, 4'd3, 32'h5555_0003, 4'd3, 4'd3, ma, aa);
        check("dual_acc", 64'({ma, aa}), 64'b11);
        idle(3, 4'd3, 4'd9);
        check("dual_r3", 64'(tb_bank[3]), 64'h5555_0003);

        // Forwarding miss on A, hit on B, then miss after drain.
        step(1'b0, 4'h0, 32'h0, 1'b1, 4'd7, 32'h0707_0707, 4'd8, 4'd7, ma, aa);
        idle(3, 4'd8, 4'd7);

        // Saturating traffic: loads carry even registers, ALU odd ones.
        nm = 0; na = 0; guard = 0;
        while ((nm < 8 || na < 8) && guard < 100) begin
            step(nm < 8, 4'(2*nm), 32'(2*nm), na < 8, 4'(2*na+1), 32'(2*na+1), 4'(guard), 4'(guard+1), ma, aa);
            if (ma) nm++;
            if (aa) na++;
            guard++;
        end
        check("sat_done", 64'(guard < 100), 64'd1);
        idle(DEPTH + 1, 4'd0, 4'd1);
        check("sat_max_count", 64'(dut_max_count), 64'd4);
        for (int i = 0; i < 16; i++) check("sat_bank", 64'(tb_bank[i]), 64'(i));
        compare_bank("sat_model_bank");

        // Reset with three writes pending: they are discarded.
        step(1'b1, 4'd10, 32'hBAD0_000A, 1'b1, 4'd11, 32'hBAD0_000B, 4'd11, 4'd12, ma, aa);
        step(1'b1, 4'd12, 32'hBAD0_000C, 1'b1, 4'd13, 32'hBAD0_000D, 4'd12, 4'd13, ma, aa);
        @(negedge clk);
        mem_valid = 1'b0; alu_valid = 1'b0;
        ra = 4'd12; rb = 4'd13;
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_w_rb",  64'(w_rb),      64'd0);
        check("mid_rst_wc",    64'(wc),        64'd0);
        check("mid_rst_wpc",   64'(wpc),       64'd0);
        check("mid_rst_count", 64'(count),     64'd0);
        check("mid_rst_empty", 64'(empty),     64'd1);
        check("mid_rst_fwd_a", 64'(fwd_a_hit), 64'd0);
        q.delete();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        idle(2, 4'd12, 4'd13);
        compare_bank("post_rst_bank");
        check("post_rst_r12", 64'(tb_bank[12]), 64'(32'd12));

        // Random traffic.
        for (int i = 0; i < 200; i++) begin
            step(1'($urandom), 4'($urandom), $urandom, 1'($urandom), 4'($urandom), $urandom,
                 4'($urandom), 4'($urandom), ma, aa);
        end
        idle(DEPTH + 2, 4'd0, 4'd15);
        check("rand_drained", 64'(empty), 64'd1);
        compare_bank("rand_bank");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
